// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: ALU operation codes, opcode and funct
// constants, sequencer state encoding and the decoded control bundle.
package alu_pkg;

  // ALU operation select
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Major opcodes handled by the sequencer
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDecode = 2'b01,
    StExec   = 2'b10,
    StWb     = 2'b11
  } state_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [31:0] imm;
  } ctrl_t;

  // ALU op for a funct3 using the base (non-alternate) funct7 encoding
  function automatic logic [3:0] base_op(logic [2:0] funct3);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      F3_ADD:  op = ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_sequencer_decoder.sv
// Combinational decoder for RV32I register-register and register-immediate
// ALU instructions. Flags anything else as illegal.
module instr_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_control,
  output logic        alu_src,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // For I-type this is imm[11:5], which qualifies the shift encodings
  assign funct7 = instr[31:25];

  // Field extraction and legality check
  always_comb begin
    rs1         = instr[19:15];
    rs2         = 5'd0;
    rd          = instr[11:7];
    alu_control = ALU_ADD;
    alu_src     = 1'b0;
    imm         = 32'd0;
    illegal     = 1'b0;

    case (opcode)
      OP_R: begin
        rs2 = instr[24:20];
        if (funct7 == F7_BASE) begin
          alu_control = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_control = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_control = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end

      OP_I: begin
        alu_src     = 1'b1;
        alu_control = base_op(funct3);
        imm         = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          F3_SLL: begin
            imm = {27'd0, instr[24:20]};
            if (funct7 != F7_BASE) illegal = 1'b1;
          end
          F3_SR: begin
            imm = {27'd0, instr[24:20]};
            if (funct7 == F7_ALT) begin
              alu_control = ALU_SRA;
            end else if (funct7 != F7_BASE) begin
              illegal = 1'b1;
            end
          end
          default: ;
        endcase
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state control sequencer (IDLE, DECODE, EXEC, WB) driving the register
// file and ALU for one integer ALU instruction at a time.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [3:0]          alu_control,
  output logic                alu_src,
  output logic [31:0]         imm,
  output logic                reg_write,
  output logic                illegal,
  output logic                busy,
  output logic [RETIRE_W-1:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  ctrl_t       dec;
  logic        dec_illegal;
  logic        accept;

  assign instr_ready = (state_q == StIdle);
  assign busy        = ~instr_ready;
  assign accept      = instr_valid & instr_ready;

  instr_decoder u_decoder (
    .instr       (instr_q),
    .rs1         (dec.rs1),
    .rs2         (dec.rs2),
    .rd          (dec.rd),
    .alu_control (dec.alu_control),
    .alu_src     (dec.alu_src),
    .imm         (dec.imm),
    .illegal     (dec_illegal)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = dec_illegal ? StIdle : StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register and instruction capture on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
    end
  end

  // Control fields load only on a legal decode and hold until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      alu_control <= ALU_ADD;
      alu_src     <= 1'b0;
      imm         <= 32'd0;
    end else if (state_q == StDecode && !dec_illegal) begin
      rs1         <= dec.rs1;
      rs2         <= dec.rs2;
      rd          <= dec.rd;
      alu_control <= dec.alu_control;
      alu_src     <= dec.alu_src;
      imm         <= dec.imm;
    end
  end

  // Single-cycle pulses: write enable during WB, illegal in the cycle after DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // x0 writes are dropped here so the register file never sees them
      reg_write <= (state_q == StExec) && (rd != 5'd0);
      illegal   <= (state_q == StDecode) && dec_illegal;
    end
  end

  // Retire counter advances on the closing edge of WB and wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (state_q == StWb) begin
      retired <= retired + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes expected decode results,
// monitor pops them when the DUT returns to idle and checks fields, pulses,
// timing, retire counts and the resulting architectural register values.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready, reg_write, illegal, busy, alu_src;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control;
  logic [31:0] imm;
  logic [31:0] retired;

  // Narrow-counter instance for the wrap check
  logic        instr_ready2, reg_write2, illegal2, busy2, alu_src2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [3:0]  alu_control2;
  logic [31:0] imm2;
  logic [1:0]  retired2;

  always #5 clk = ~clk;

  alu_sequencer #(.RETIRE_W(32)) u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control),
    .alu_src(alu_src), .imm(imm), .reg_write(reg_write), .illegal(illegal),
    .busy(busy), .retired(retired)
  );

  alu_sequencer #(.RETIRE_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready2),
    .instr(instr), .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .alu_control(alu_control2),
    .alu_src(alu_src2), .imm(imm2), .reg_write(reg_write2), .illegal(illegal2),
    .busy(busy2), .retired(retired2)
  );

  typedef struct {
    logic        legal;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctl;
    logic        src;
    logic [31:0] imm;
    logic [31:0] word;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        init_rf = 1'b0;
  logic [31:0] rf[32];
  logic [31:0] arch[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] seed_val(int i);
    return (i == 0) ? 32'd0 : (32'(i) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // ALU op by funct3 and the alternate-encoding flag
  function automatic logic [3:0] op_of(logic [2:0] f3, logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    e.word = w; e.rs1 = w[19:15]; e.rd = w[11:7]; e.acc = 0;
    e.rs2 = 5'd0; e.ctl = 4'd0; e.src = 1'b0; e.imm = 32'd0; e.legal = 1'b0;
    if (w[6:0] == 7'h33) begin
      e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.rs2   = w[24:20];
      e.ctl   = op_of(f3, f7 == 7'h20);
    end else if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1)      e.legal = (f7 == 7'h00);
      else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
      else                 e.legal = 1'b1;
      e.src = 1'b1;
      e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      e.ctl = op_of(f3, f3 == 3'd5 && f7 == 7'h20);
    end
    return e;
  endfunction

  // Architectural result of a legal instruction, from its RISC-V meaning
  function automatic logic [31:0] ref_exec(logic [31:0] w, logic [31:0] a, logic [31:0] b);
    logic alt;
    alt = w[30];
    case (w[14:12])
      3'd0: return (w[6:0] == 7'h33 && alt) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU seen by the register file, selected by alu_control
  function automatic logic [31:0] bench_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 3))
      0: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      1: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      2: w[6:0] = 7'h33;
      default: ;
    endcase
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register file driven by the DUT's control outputs
  always @(posedge clk) begin
    if (init_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed_val(i);
    end else if (!reset && reg_write && rd != 5'd0) begin
      rf[rd] <= bench_alu(alu_control, rf[rs1], alu_src ? imm : rf[rs2]);
    end
  end

  // Monitor: one completion per return to idle
  initial begin : monitor
    logic        prev_busy;
    int          rw_cnt;
    int          rw_cyc;
    logic [31:0] exp_ret;
    exp_t        e;
    logic [4:0]  h_rs1, h_rs2, h_rd;
    logic [3:0]  h_ctl;
    logic        h_src;
    logic [31:0] h_imm;
    logic [31:0] res;
    prev_busy = 1'b0; rw_cnt = 0; rw_cyc = -1; exp_ret = 32'd0;
    h_rs1 = 5'd0; h_rs2 = 5'd0; h_rd = 5'd0; h_ctl = 4'd0; h_src = 1'b0; h_imm = 32'd0;
    for (int i = 0; i < 32; i++) arch[i] = seed_val(i);
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        prev_busy = 1'b0; rw_cnt = 0; exp_ret = 32'd0;
        h_rs1 = 5'd0; h_rs2 = 5'd0; h_rd = 5'd0; h_ctl = 4'd0; h_src = 1'b0; h_imm = 32'd0;
        continue;
      end
      check("busy_vs_ready", busy, !instr_ready);
      if (reg_write) begin
        rw_cnt++;
        rw_cyc = cyc;
      end
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          e = q.pop_front();
          check("illegal_pulse", illegal, !e.legal);
          check("done_cycle", cyc, e.acc + (e.legal ? 4 : 2));
          if (e.legal) begin
            h_rs1 = e.rs1; h_rs2 = e.rs2; h_rd = e.rd; h_ctl = e.ctl; h_src = e.src; h_imm = e.imm;
            exp_ret = exp_ret + 32'd1;
          end
          check("rs1", rs1, h_rs1);
          check("rs2", rs2, h_rs2);
          check("rd", rd, h_rd);
          check("alu_control", alu_control, h_ctl);
          check("alu_src", alu_src, h_src);
          check("imm", imm, h_imm);
          check("reg_write_pulses", rw_cnt, (e.legal && e.rd != 5'd0) ? 1 : 0);
          if (rw_cnt == 1) check("wb_cycle", rw_cyc, e.acc + 3);
          check("retired", retired, exp_ret);
          check("retired_w2", retired2, exp_ret[1:0]);
          if (e.legal && e.rd != 5'd0) begin
            res = ref_exec(e.word, arch[e.rs1], e.src ? e.imm : arch[e.rs2]);
            arch[e.rd] = res;
            check("rf_result", rf[e.rd], res);
          end
        end
        rw_cnt = 0;
      end else if (illegal) begin
        check("stray_illegal", illegal, 0);
      end
      prev_busy = busy;
    end
  end

  task automatic check_reset_values();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_illegal", illegal, 0);
    check("rst_fields", {rs1, rs2, rd, alu_control, alu_src}, 0);
    check("rst_imm", imm, 0);
    check("rst_retired", retired, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      $display("FAIL ready_timeout actual=busy required=ready");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "ready timeout");
    end
  endtask

  // Offer one word for a single cycle once the DUT is ready
  task automatic send(input logic [31:0] w);
    exp_t e;
    wait_ready();
    instr_valid = 1'b1;
    instr = w;
    e = ref_decode(w);
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom();
  endtask

  initial begin : driver
    exp_t        e;
    int          acc_cyc[$];
    int          n;
    logic [31:0] saved;
    logic [31:0] dir[7];
    dir[0] = 32'h002081B3; dir[1] = 32'h407302B3; dir[2] = 32'hFFF08213;
    dir[3] = 32'h40315113; dir[4] = 32'h00000000; dir[5] = 32'h40001033;
    dir[6] = 32'h00208033;

    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; init_rf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    init_rf = 1'b0;
    #2 reset = 1'b0;

    for (int i = 0; i < 7; i++) send(dir[i]);

    // Held-valid throughput
    wait_ready();
    n = 0;
    while (acc_cyc.size() < 3 && n < 40) begin
      instr_valid = 1'b1;
      instr = 32'h002081B3;
      if (instr_ready) begin
        e = ref_decode(instr);
        e.acc = cyc;
        q.push_back(e);
        acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    check("held_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("accept_gap1", acc_cyc[1] - acc_cyc[0], 4);
      check("accept_gap2", acc_cyc[2] - acc_cyc[1], 4);
    end

    // Random traffic with random valid, including while busy
    for (int i = 0; i < 300; i++) begin
      instr_valid = ($urandom_range(0, 1) == 1);
      instr = gen_instr();
      if (instr_valid && instr_ready) begin
        e = ref_decode(instr);
        e.acc = cyc;
        q.push_back(e);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n = 0;
    while ((busy || q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);

    // Abort in EXEC (t=2) and in WB (t=3)
    for (int t = 2; t <= 3; t++) begin
      saved = rf[5];
      send(32'h407302B3);
      for (int k = 1; k < t; k++) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_values();
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      check("abort_no_write", rf[5], saved);
      check("abort_arch", rf[5], arch[5]);
    end

    // Retire five after reset: narrow counter wraps to 1
    for (int i = 0; i < 5; i++) send(32'h002081B3);
    wait_ready();
    @(negedge clk);
    check("retired_five", retired, 5);
    check("retired_w2_wrap", retired2, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the register file and ALU for RISC-V integer ALU instructions. It accepts one 32-bit instruction per valid/ready handshake and decodes R-type and I-type ALU operations. It then drives the register-file read/write addresses, the ALU operation select, the operand-B source/immediate and a single-cycle `reg_write` pulse. It sits between the instruction source (fetch unit or testbench) and the `RegisterFile`/`ALU` pair inside `CPU`, replacing hardcoded control.

## Interface
- `RETIRE_W`, 32, width of retired-instruction counter
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; returns block to IDLE
- `instr_valid`  in  1  instruction word offered
- `instr_ready`  out  1  block can accept (high only in IDLE)
- `instr`  in  32  RISC-V instruction word
- `rs1`, `rs2`, `rd`  out  5 each  register-file read/write addresses
- `alu_control`  out  4  ALU operation select
- `alu_src`  out  1  0 = ALU b from `read_data2`, 1 = from `imm`
- `imm`  out  32  operand-B immediate
- `reg_write`  out  1  register-file write enable, one-cycle pulse
- `illegal`  out  1  one-cycle pulse: rejected instruction
- `busy`  out  1  state != IDLE
- `retired`  out  RETIRE_W  count of completed legal instructions, wraps

## Operation
- States: IDLE, DECODE, EXEC, WB.
  - IDLE→DECODE on `instr_valid && instr_ready`; `instr` captured into an internal register.
  - DECODE→EXEC if legal; DECODE→IDLE if illegal.
  - EXEC→WB unconditionally; WB→IDLE unconditionally.
- `alu_control` encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- R-type (opcode 0110011) rules:
  - funct7 0000000 allows any funct3.
  - funct7 0100000 allows funct3 000 (SUB) or 101 (SRA) only.
  - Outputs: `alu_src`=0, `imm`=0.
- I-type (opcode 0010011) rules:
  - funct3 001 requires imm[11:5]=0000000.
  - funct3 101 requires imm[11:5] = 0000000 (SRLI) or 0100000 (SRAI).
  - Outputs: `alu_src`=1, `rs2`=0.
  - `imm` = sign-extended instr[31:20]; for shifts, `imm` = zero-extended instr[24:20].
- Any other opcode/funct combination is illegal:
  - `illegal` pulses; no `reg_write`; `retired` unchanged.
- `rd`=0 on a legal instruction:
  - `reg_write` is suppressed in WB.
  - The instruction still retires (`retired` increments).
- All outputs except `instr_ready`/`busy` are registered.
  - `rs1/rs2/rd/alu_control/alu_src/imm` load on the DECODE→EXEC edge.
  - They hold through WB and in the following IDLE until the next legal decode.
  - Illegal decode does not alter them.
- `instr_valid` while not ready is ignored; the source need not hold it.

## Timing
- Cycle numbering: accept edge at end of cycle 0.
  - Cycle 1: DECODE.
  - Cycle 2: EXEC; fields stable, ALU settles, `reg_write`=0.
  - Cycle 3: WB; `reg_write`=1, register file writes on the closing edge, `retired` increments on that same edge.
  - Cycle 4: IDLE, `instr_ready`=1.
- Throughput: one instruction per 4 cycles when `instr_valid` is held high.
- Illegal path: `illegal`=1 during cycle 2 (IDLE, `instr_ready`=1); next accept is possible at end of cycle 2.
- Reset values: state IDLE; `instr_ready`=1; `busy`=0; all other outputs 0; `retired`=0.
- Reset asserted in any state (including mid-EXEC/WB) aborts immediately: `reg_write` drops asynchronously and no write is committed.
- `retired` wraps from 2^RETIRE_W−1 to 0.

## Structure
- Package `alu_pkg`:
  - `alu_control` localparams.
  - Opcode constants OP_R=0110011, OP_I=0010011.
  - funct7 constants.
  - State enum.
- Shared by `ALU`, `CPU` and this block.
- Sub-module `instr_decoder`: purely combinational, `instr` → `rs1, rs2, rd, alu_control, alu_src, imm, illegal`.
- Top of block: FSM, output registers and retire counter.

## Test plan
- ADD x3,x1,x2 (0x002081B3) → cycle 3: `rs1`=1, `rs2`=2, `rd`=3, `alu_control`=0000, `alu_src`=0, `reg_write` high exactly one cycle; `retired`=1.
- SUB x5,x6,x7 (0x407302B3) → `alu_control`=0001, `rd`=5; register-file x5 = x6−x7 after WB.
- ADDI x4,x1,−1 (0xFFF08213) → `alu_src`=1, `imm`=0xFFFFFFFF, `rs2`=0; SRAI x2,x2,3 (0x40315113) → `alu_control`=0111, `imm`=3.
- Illegal 0x00000000 and 0x40001033 (SLL with funct7 0100000) → `illegal` pulse in cycle 2, no `reg_write`, `retired` unchanged, fields unchanged; ADD x0,x1,x2 (0x00208033) → no `reg_write`, `retired`+1.
- `instr_valid` held high with 3 ADDs → accepts at cycles 0, 4, 8; `busy` low only in IDLE; `retired`=3.
- `reset` asserted during EXEC → immediate IDLE, all outputs at reset values, no register-file write; `RETIRE_W`=2 with 5 retirements → `retired`=1.
